xor_frame_parity: RTL and testbench
===================================

# xor_frame_parity

Streaming parity unit, next generation of the team's single-bit XOR gate designs. Accepts WIDTH-bit data beats over a valid/ready handshake and folds them into a running column-wise XOR across a frame that is closed by `in_last`. For each frame it returns the folded word, a single parity bit (even or odd mode), the beat count and an overflow flag on a second valid/ready handshake. It sits between a word source and a checker or transmitter that needs per-frame parity.

## Interface
- `WIDTH`, 8: data beat width in bits; ≥1.
- `MAX_LEN`, 16: maximum counted beats per frame; ≥1. Count width `CW = $clog2(MAX_LEN+1)`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  unit can accept a beat.
- `in_data`  in  WIDTH  beat data.
- `in_last`  in  1  beat closes the frame.
- `odd_mode`  in  1  0 = even parity, 1 = odd parity; sampled on the first beat of a frame.
- `out_valid`  out  1  frame result present.
- `out_ready`  in  1  consumer takes the result.
- `out_word_xor`  out  WIDTH  XOR of all beats in the frame.
- `out_parity`  out  1  `^out_word_xor ^ odd_mode_latched`.
- `out_count`  out  CW  accepted beats, saturating at MAX_LEN.
- `out_overflow`  out  1  frame had more than MAX_LEN beats.

## Operation
- States: ACCUM and HOLD.
- ACCUM:
  - `in_ready=1`, `out_valid=0`.
  - An accepted beat (`in_valid & in_ready`) sets `acc <= acc ^ in_data` and `cnt <= min(cnt+1, MAX_LEN)`.
  - If the beat arrives with `cnt==MAX_LEN`, `ovf <= 1`; the data is still folded in.
  - The first beat of a frame (`cnt==0`, no overflow yet) latches `odd_mode`.
  - An accepted beat with `in_last=1` updates the accumulators as above and moves the state to HOLD.
- HOLD:
  - `in_ready=0`, `out_valid=1`.
  - Outputs are driven from the registered accumulators and are stable while `out_ready=0`.
  - When `out_ready=1`: clear `acc`, `cnt`, `ovf` and the latched mode, and return to ACCUM.
- Single-beat frames are legal (first beat with `in_last=1`).
- Gaps with `in_valid=0` inside a frame change nothing.
- `in_data`, `in_last` and `odd_mode` are ignored when no beat is accepted.
- Reset values: state=ACCUM, `acc=0`, `cnt=0`, `ovf=0`, mode latch=0. Output pins during reset: `in_ready=1`, `out_valid=0`, `out_word_xor=0`, `out_parity=0`, `out_count=0`, `out_overflow=0`.
- Reset mid-frame or while in HOLD discards the partial or pending result. No output beat is produced for it.

## Timing
- Result latency: `out_valid` rises on the cycle after the `in_last` beat is accepted.
- In HOLD, `in_ready=0`, giving exactly one bubble: the earliest next input is accepted on the cycle after the output handshake.
- Minimum cycles per N-beat frame: N+1, with `out_ready` held high.
- `in_ready` and `out_valid` depend only on the registered state, with no combinational path from `in_valid` or `out_ready`.
- `rst` has priority over any handshake in the same cycle.

## Structure
- Shared package `xor_pkg` holds:
  - state enum `xfp_state_t {ACCUM, HOLD}`;
  - the `CW` computation helper function.
- Sub-module `xor_reduce #(WIDTH)`: combinational WIDTH-bit reduction XOR, used to produce `out_parity` from `acc`.
- The top level holds the FSM, the accumulators and the handshakes.

## Test plan
All scenarios use WIDTH=8, MAX_LEN=4.
- Single beat 0xA5 with `in_last=1`, `odd_mode=0` → next cycle `out_valid=1`, `out_word_xor=0xA5`, `out_parity=0`, `out_count=1`, `out_overflow=0`.
- Frame 0x0F, 0xF0, 0xFF(last) with `odd_mode=0` → `out_word_xor=0x00`, `out_parity=0`, `out_count=3`. Repeat with `odd_mode=1` on the first beat only → `out_parity=1`.
- Five beats of 0x01, last on the fifth → `out_word_xor=0x01`, `out_parity=1`, `out_count=4`, `out_overflow=1`.
- Hold `out_ready=0` for 3 cycles after result 0x5A → outputs stable, `in_ready=0`, and a beat offered during this time is not accepted. Raise `out_ready` → next cycle `in_ready=1`.
- Send beats 0x11 and 0x22, then assert `rst` for 1 cycle, then send 0x3C(last) → `out_word_xor=0x3C`, `out_count=1`, no earlier result emitted.
- Frame 0x81, then 2 idle cycles, then 0x18(last) → `out_word_xor=0x99`, `out_count=2`, same result as the back-to-back case.

Source files
------------

// File: rtl/xor_pkg.sv
// Shared definitions for the xor_frame_parity streaming parity unit.
package xor_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } xfp_state_t;

  // Bits needed to hold a beat count in the range 0..max_len.
  function automatic int unsigned cnt_width(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/xor_reduce.sv
// Combinational reduction XOR across a WIDTH-bit word.
module xor_reduce #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  always_comb begin
    parity = ^data;
  end

endmodule

// File: rtl/xor_frame_parity.sv
// Folds valid/ready beats into a per-frame column XOR and returns the word,
// the parity bit, the saturating beat count and an overflow flag.
module xor_frame_parity
  import xor_pkg::*;
#(
  parameter int unsigned  WIDTH   = 8,
  parameter int unsigned  MAX_LEN = 16,
  localparam int unsigned CW      = cnt_width(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             odd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word_xor,
  output logic             out_parity,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LEN);

  xfp_state_t       state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             mode_q;
  logic             acc_par;
  logic             beat;

  assign beat = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ACCUM;
      acc    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (beat) begin
        acc <= acc ^ in_data;
        // Count saturates; a beat past the limit flags overflow but is still folded.
        if (cnt == CNT_MAX) ovf <= 1'b1;
        else                cnt <= cnt + CW'(1);
        if (cnt == '0 && !ovf) mode_q <= odd_mode;
      end else if (state == HOLD && out_ready) begin
        acc    <= '0;
        cnt    <= '0;
        ovf    <= 1'b0;
        mode_q <= 1'b0;
      end
    end
  end

  xor_reduce #(.WIDTH(WIDTH)) u_reduce (
    .data   (acc),
    .parity (acc_par)
  );

  always_comb begin
    out_word_xor = acc;
    out_parity   = acc_par ^ mode_q;
    out_count    = cnt;
    out_overflow = ovf;
  end

endmodule

// File: tb/tb_xor_frame_parity.sv
// Self-checking bench for xor_frame_parity with WIDTH=8, MAX_LEN=4.
module tb_xor_frame_parity;

  localparam int unsigned W  = 8;
  localparam int unsigned ML = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last, odd_mode;
  logic [W-1:0]  in_data;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_word_xor;
  logic          out_parity;
  logic [CW-1:0] out_count;
  logic          out_overflow;

  int unsigned total = 0;
  int unsigned bad   = 0;

  xor_frame_parity #(.WIDTH(W), .MAX_LEN(ML)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .odd_mode     (odd_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_word_xor (out_word_xor),
    .out_parity   (out_parity),
    .out_count    (out_count),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  // Expected result packed as {word, parity, count, overflow}.
  function automatic logic [12:0] model(input logic [7:0] beats[$], input logic mode);
    logic [7:0]  x = 8'h00;
    int unsigned n = beats.size();
    int unsigned c;
    foreach (beats[i]) x = x ^ beats[i];
    c = (n > ML) ? ML : n;
    return {x, logic'(($countones(x) % 2) != 0) ^ mode, 3'(c), logic'(n > ML)};
  endfunction

  function automatic logic [12:0] outs();
    return {out_word_xor, out_parity, out_count, out_overflow};
  endfunction

  // Offers one beat (entered and left at a negedge), waiting for in_ready.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic m);
    int unsigned n = 0;
    in_valid = 1'b1; in_data = d; in_last = l; odd_mode = m;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%b required=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom); odd_mode = 1'($urandom);
  endtask

  // Waits for a result, holds it for 'stall' cycles, then completes the handshake.
  task automatic take_result(input int unsigned stall, output logic [12:0] got);
    int unsigned n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL result_timeout: out_valid=%b required=1", out_valid);
    end
    got = outs();
    for (int unsigned i = 0; i < stall; i++) begin
      @(negedge clk);
      total++;
      if ({outs(), out_valid, in_ready} !== {got, 2'b10}) begin
        bad++;
        $display("FAIL hold_stable: got=%h/%b%b required=%h/10", outs(), out_valid, in_ready, got);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] dummy;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, out_valid, outs()} !== {2'b10, 13'h0}) begin
      bad++;
      $display("FAIL reset_state: got=%b%b %h required=10 0000", in_ready, out_valid, outs());
    end
    rst = 1'b0;
    send_beat(8'h01, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, outs()} !== {2'b10, 13'h0}) begin
      bad++;
      $display("FAIL reset_in_hold: got=%b%b %h required=10 0000", in_ready, out_valid, outs());
    end
    dummy = '0;
    if (dummy !== '0) $display("unreachable");
  endtask

  task automatic test_single();
    logic [12:0] got;
    send_beat(8'hA5, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_latency: out_valid=%b required=1", out_valid);
    end
    take_result(0, got);
    total++;
    if (got !== {8'hA5, 1'b0, 3'd1, 1'b0}) begin
      bad++;
      $display("FAIL single_beat: got=%h required=%h", got, {8'hA5, 1'b0, 3'd1, 1'b0});
    end
  endtask

  task automatic test_frames();
    logic [12:0] got;
    send_beat(8'h0F, 1'b0, 1'b0);
    send_beat(8'hF0, 1'b0, 1'b1);
    send_beat(8'hFF, 1'b1, 1'b1);
    take_result(0, got);
    total++;
    if (got !== {8'h00, 1'b0, 3'd3, 1'b0}) begin
      bad++;
      $display("FAIL frame_even: got=%h required=%h", got, {8'h00, 1'b0, 3'd3, 1'b0});
    end
    send_beat(8'h0F, 1'b0, 1'b1);
    send_beat(8'hF0, 1'b0, 1'b0);
    send_beat(8'hFF, 1'b1, 1'b0);
    take_result(0, got);
    total++;
    if (got !== {8'h00, 1'b1, 3'd3, 1'b0}) begin
      bad++;
      $display("FAIL frame_odd: got=%h required=%h", got, {8'h00, 1'b1, 3'd3, 1'b0});
    end
  endtask

  task automatic test_overflow();
    logic [12:0] got;
    for (int unsigned i = 0; i < 5; i++) send_beat(8'h01, logic'(i == 4), 1'b0);
    take_result(0, got);
    total++;
    if (got !== {8'h01, 1'b1, 3'd4, 1'b1}) begin
      bad++;
      $display("FAIL overflow: got=%h required=%h", got, {8'h01, 1'b1, 3'd4, 1'b1});
    end
  endtask

  task automatic test_hold();
    logic [12:0] got;
    send_beat(8'h5A, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 8'h33; in_last = 1'b1; odd_mode = 1'b1;
    take_result(3, got);
    in_valid = 1'b0;
    total++;
    if (got !== {8'h5A, 1'b0, 3'd1, 1'b0}) begin
      bad++;
      $display("FAIL hold_value: got=%h required=%h", got, {8'h5A, 1'b0, 3'd1, 1'b0});
    end
    total++;
    if ({in_ready, out_valid, outs()} !== {2'b10, 13'h0}) begin
      bad++;
      $display("FAIL hold_release: got=%b%b %h required=10 0000", in_ready, out_valid, outs());
    end
    send_beat(8'h01, 1'b1, 1'b0);
    take_result(0, got);
    total++;
    if (got !== {8'h01, 1'b1, 3'd1, 1'b0}) begin
      bad++;
      $display("FAIL hold_no_leak: got=%h required=%h", got, {8'h01, 1'b1, 3'd1, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] got;
    send_beat(8'h11, 1'b0, 1'b1);
    send_beat(8'h22, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({out_valid, outs()} !== {1'b0, 13'h0}) begin
      bad++;
      $display("FAIL reset_mid_clear: got=%b %h required=0 0000", out_valid, outs());
    end
    send_beat(8'h3C, 1'b1, 1'b0);
    take_result(0, got);
    total++;
    if (got !== {8'h3C, 1'b0, 3'd1, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid: got=%h required=%h", got, {8'h3C, 1'b0, 3'd1, 1'b0});
    end
  endtask

  task automatic test_gap();
    logic [12:0] got;
    send_beat(8'h81, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    send_beat(8'h18, 1'b1, 1'b0);
    take_result(0, got);
    total++;
    if (got !== {8'h99, 1'b0, 3'd2, 1'b0}) begin
      bad++;
      $display("FAIL gap_frame: got=%h required=%h", got, {8'h99, 1'b0, 3'd2, 1'b0});
    end
  endtask

  task automatic test_random();
    logic [7:0]  beats[$];
    logic [12:0] got, exp;
    logic        mode;
    int unsigned len;
    for (int unsigned f = 0; f < 40; f++) begin
      beats.delete();
      len  = $urandom_range(1, 6);
      mode = 1'($urandom);
      for (int unsigned b = 0; b < len; b++) begin
        beats.push_back(8'($urandom));
        send_beat(beats[b], logic'(b == len - 1), (b == 0) ? mode : 1'($urandom));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      exp = model(beats, mode);
      take_result($urandom_range(0, 2), got);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL random_frame%0d: got=%h required=%h", f, got, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    odd_mode = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_frames();
    test_overflow();
    test_hold();
    test_reset_mid();
    test_gap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
